// File: rtl/sram_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_controller_pkg                                          |
// | Description : Constants shared by the pipeline stages and the SRAM         |
// |               controller: FSM state encoding, data-memory base address     |
// |               and the default settle-cycle count.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_controller_pkg;

  // Controller states; explicit 3-bit encoding so other stages can decode it.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_LO = 3'd1,
    S_ACC_HI = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } sram_state_t;

  // Byte address of the first data-memory word.
  localparam logic [31:0] C_DATA_MEM_BASE = 32'd1024;

  // Extra settle cycles after the two half-word accesses (legal 1..15).
  localparam int unsigned C_WAIT_CYCLES_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_controller                                              |
// | Description : MEM-stage bridge from a 32-bit load/store request to a       |
// |               16-bit asynchronous SRAM. Each access is split into a low    |
// |               and a high half-word cycle followed by WAIT_CYCLES settle    |
// |               cycles; ready is held low to freeze the pipeline meanwhile.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES   = C_WAIT_CYCLES_DEFAULT,
  parameter logic [31:0] DATA_MEM_BASE = C_DATA_MEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  // The counter is loaded with one less than the cycle count and exits at zero.
  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_t r_state;
  sram_state_t w_next_state;
  logic [3:0]  r_wait_cnt;
  logic        r_is_write;
  logic [16:0] r_offset;
  logic [31:0] r_wdata;
  logic [15:0] r_rd_lo;
  logic [31:0] r_read_data;

  logic        w_req;
  logic [31:0] w_addr_diff;
  logic        w_unused_diff;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;

  assign w_req         = wr_en | rd_en;
  assign w_addr_diff   = address - DATA_MEM_BASE;
  // Only the word offset bits [18:2] reach the 18-bit half-word address bus.
  assign w_unused_diff = ^{w_addr_diff[31:19], w_addr_diff[1:0]};

  assign read_data = r_read_data;

  // Byte lanes, chip enable and output enable are permanently active.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Bus is driven only during the two strobe cycles of a write.
  assign SRAM_DQ = w_dq_oe ? w_dq_out : 16'bz;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operation latch, settle counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= 4'd0;
      r_is_write  <= 1'b0;
      r_offset    <= 17'd0;
      r_wdata     <= 32'd0;
      r_rd_lo     <= 16'd0;
      r_read_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Freeze the operation so later input changes cannot affect it;
          // a write wins when both enables are high.
          if (w_req) begin
            r_is_write <= wr_en;
            r_offset   <= w_addr_diff[18:2];
            r_wdata    <= write_data;
          end
        end
        S_ACC_LO: begin
          if (!r_is_write) begin
            r_rd_lo <= SRAM_DQ;
          end
        end
        S_ACC_HI: begin
          r_wait_cnt <= C_WAIT_LOAD;
          // Commit both halves together so read_data only changes when a
          // read has fully completed.
          if (!r_is_write) begin
            r_read_data <= {SRAM_DQ, r_rd_lo};
          end
        end
        S_WAIT: begin
          if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and SRAM strobes decoded from the current state.
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b1;
    SRAM_WE_N    = 1'b1;
    SRAM_ADDR    = 18'd0;
    w_dq_oe      = 1'b0;
    w_dq_out     = 16'd0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          ready        = 1'b0;
          w_next_state = S_ACC_LO;
        end
      end
      S_ACC_LO: begin
        ready        = 1'b0;
        SRAM_ADDR    = {r_offset, 1'b0};
        SRAM_WE_N    = ~r_is_write;
        w_dq_oe      = r_is_write;
        w_dq_out     = r_wdata[15:0];
        w_next_state = S_ACC_HI;
      end
      S_ACC_HI: begin
        ready        = 1'b0;
        SRAM_ADDR    = {r_offset, 1'b1};
        SRAM_WE_N    = ~r_is_write;
        w_dq_oe      = r_is_write;
        w_dq_out     = r_wdata[31:16];
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        ready = 1'b0;
        if (r_wait_cnt == 4'd0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_controller                                           |
// | Description : Randomised scoreboard bench for sram_controller with an      |
// |               SRAM model on the bidirectional bus and a word-level          |
// |               reference memory.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_controller;

  localparam int          W    = 2;
  localparam int          LAT  = 3 + W;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    logic        is_wr;
    logic [31:0] exp_rd;
    int          word;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        ub_n, lb_n, ce_n, oe_n;

  logic [15:0] sram [0:255];
  logic [31:0] ref_mem [0:63];
  logic [31:0] model_rd;
  logic        read_active = 1'b0;
  exp_t        sb_q[$];
  logic [17:0] tr_addr[$];
  logic [15:0] tr_dq[$];
  logic        tr_we[$];
  int          req_cycle;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          we_low = 0;

  sram_controller #(.WAIT_CYCLES(W), .DATA_MEM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  // SRAM drives the bus only while the bench has a pure read outstanding.
  assign SRAM_DQ = (read_active && SRAM_WE_N) ? sram[SRAM_ADDR[7:0]] : 16'hzzzz;

  // Weak pull-ups make an undriven bus read back as all ones.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (SRAM_DQ[g]);
  end

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the oldest expectation whenever ready returns high after a busy span.
  task automatic monitor();
    int   lowcnt;
    exp_t e;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lowcnt = 0;
      end else if (!ready) begin
        lowcnt++;
      end else if (lowcnt > 0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got completion expected none (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("latency", 32'(lowcnt), 32'(LAT));
          check("read_data", read_data, e.exp_rd);
          if (e.is_wr) begin
            check("sram_lo", 32'(sram[2*e.word]), 32'(e.wdata[15:0]));
            check("sram_hi", 32'(sram[2*e.word+1]), 32'(e.wdata[31:16]));
          end
        end
        lowcnt = 0;
      end
    end
  endtask

  // Issues one request, records a per-cycle bus trace, returns in the DONE cycle.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data);
    exp_t e;
    int   w;
    bit   done;
    done = 1'b0;
    w = int'((addr - BASE) / 32'd4);
    e.is_wr = wr;
    e.word  = w;
    e.wdata = data;
    if (wr) begin
      ref_mem[w] = data;
      e.exp_rd   = model_rd;
    end else begin
      model_rd = ref_mem[w];
      e.exp_rd = model_rd;
    end
    @(posedge clk);
    #1;
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    read_active = rd && !wr;
    sb_q.push_back(e);
    req_cycle = cyc;
    tr_addr.delete(); tr_dq.delete(); tr_we.delete();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      tr_addr.push_back(SRAM_ADDR);
      tr_dq.push_back(SRAM_DQ);
      tr_we.push_back(SRAM_WE_N);
      if (ready) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      // Inputs are ignored once the operation is latched; scramble them.
      wr_en = 1'($urandom); rd_en = 1'($urandom);
      address = $urandom; write_data = $urandom;
    end
    read_active = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no ready expected ready within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  initial begin
    int d, n0, n1, k, wd, gap;
    for (int i = 0; i < 256; i++) sram[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) ref_mem[i] = {sram[2*i+1], sram[2*i]};
    model_rd = 32'd0;
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin
        @(negedge clk);
        if (!SRAM_WE_N) begin
          sram[SRAM_ADDR[7:0]] = SRAM_DQ;
          we_low++;
        end
      end
      monitor();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_dq_z", 32'(SRAM_DQ), 32'hFFFF);
    check("rst_ready", 32'(ready), 32'd1);
    check("tieoffs", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed write with per-cycle bus trace.
    issue(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    check("wr_trace_len", 32'(tr_addr.size()), 32'(LAT + 1));
    if (tr_addr.size() >= 4) begin
      check("wr_req_we_n", 32'(tr_we[0]), 32'd1);
      check("wr_lo_addr", 32'(tr_addr[1]), 32'd2);
      check("wr_lo_dq", 32'(tr_dq[1]), 32'hBEEF);
      check("wr_lo_we_n", 32'(tr_we[1]), 32'd0);
      check("wr_hi_addr", 32'(tr_addr[2]), 32'd3);
      check("wr_hi_dq", 32'(tr_dq[2]), 32'hDEAD);
      check("wr_hi_we_n", 32'(tr_we[2]), 32'd0);
      check("wr_wait_we_n", 32'(tr_we[3]), 32'd1);
      check("wr_wait_dq_z", 32'(tr_dq[3]), 32'hFFFF);
    end
    idle(1);

    // Directed read of the same word: no write strobe allowed.
    n0 = we_low;
    issue(1'b0, 1'b1, 32'd1028, 32'd0);
    check("rd_value", read_data, 32'hDEADBEEF);
    check("rd_no_strobe", 32'(we_low - n0), 32'd0);
    idle(1);

    // Quiet bus for ten cycles.
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(SRAM_WE_N), 32'd1);
      check("idle_dq_z", 32'(SRAM_DQ), 32'hFFFF);
      check("idle_read_data", read_data, model_rd);
    end

    // Both enables high: write wins, read_data untouched.
    issue(1'b1, 1'b1, 32'd1024, 32'h12345678);
    idle(1);
    check("both_word0", 32'(sram[0]), 32'h5678);
    check("both_word1", 32'(sram[1]), 32'h1234);
    check("both_read_data", read_data, 32'hDEADBEEF);

    // Back-to-back reads advanced on ready.
    issue(1'b0, 1'b1, 32'd1024, 32'd0);
    d = cyc;
    issue(1'b0, 1'b1, 32'd1032, 32'd0);
    check("b2b_req_cycle", 32'(req_cycle), 32'(d + 1));
    if (tr_addr.size() >= 3) begin
      check("b2b_lo_addr", 32'(tr_addr[1]), 32'd4);
      check("b2b_hi_addr", 32'(tr_addr[2]), 32'd5);
    end
    idle(1);

    // Random mix of reads, writes and combined requests with random gaps.
    for (int i = 0; i < 40; i++) begin
      k   = int'($urandom_range(0, 2));
      wd  = int'($urandom_range(0, 63));
      issue(k != 1, k != 0, BASE + 32'(4 * wd), $urandom);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end
    idle(1);

    // Reset during the high half of a write.
    issue(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 32'd1040, 32'd0);
    idle(1);
    n0 = we_low;
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1044; write_data = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n1 = we_low;
    check("abort_strobes", 32'(n1 - n0), 32'd2);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    check("abort_read_data", read_data, 32'd0);
    check("abort_addr", 32'(SRAM_ADDR), 32'd0);
    check("abort_dq_z", 32'(SRAM_DQ), 32'hFFFF);
    repeat (8) @(negedge clk);
    check("abort_no_more_strobes", 32'(we_low), 32'(n1));
    ref_mem[5] = 32'h0BADF00D;
    model_rd   = 32'd0;
    issue(1'b0, 1'b1, 32'd1044, 32'd0);
    idle(2);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of extra settle cycles after the two half-word accesses (legal 1..15).
REQ-002 Parameter: DATA_MEM_BASE, default 1024, byte address of the first data-memory word.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  MEM-stage store request.
REQ-006 rd_en  input  1  MEM-stage load request.
REQ-007 address  input  32  byte address from the EXE/MEM register (ALU result).
REQ-008 write_data  input  32  store data (Val_Rm after forwarding).
REQ-009 read_data  output  32  load result to MEM/WB register.
REQ-010 ready  output  1  high = access complete or no access; low = pipeline freeze.
REQ-011 SRAM_DQ  inout  16  external data bus.
REQ-012 SRAM_ADDR  output  18  external half-word address.
REQ-013 SRAM_WE_N  output  1  external write enable, active low.
REQ-014 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0.

Function
REQ-015 States: IDLE, ACC_LO, ACC_HI, WAIT, DONE; encoding from the shared constants file.
REQ-016 Word offset = (address - DATA_MEM_BASE) >> 2, low 17 bits used; SRAM_ADDR = {offset[16:0], 1'b0} in ACC_LO and {offset[16:0], 1'b1} in ACC_HI, 0 elsewhere.
REQ-017 IDLE: if wr_en or rd_en is high, next state ACC_LO; otherwise remain in IDLE.
REQ-018 ACC_LO -> ACC_HI -> WAIT unconditionally; WAIT holds for WAIT_CYCLES cycles (4-bit down-counter loaded on entry), then DONE; DONE -> IDLE unconditionally.
REQ-019 ready is combinational: 0 when state is IDLE and (wr_en or rd_en), 0 in ACC_LO/ACC_HI/WAIT, 1 in DONE, 1 in IDLE with no request.
REQ-020 Latency: ready is low for exactly 3 + WAIT_CYCLES cycles, starting with the request cycle, then high for one DONE cycle.
REQ-021 Write: SRAM_WE_N = 0 only in ACC_LO and ACC_HI; SRAM_DQ is driven with write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI, and is high-Z in all other states.
REQ-022 Read: SRAM_WE_N = 1; SRAM_DQ is high-Z. SRAM_DQ is sampled into read_data[15:0] at the end of ACC_LO and into read_data[31:16] at the end of ACC_HI.
REQ-023 read_data holds its value until the next read completes; writes never modify it.
REQ-024 The operation is latched on leaving IDLE; input changes during ACC_LO through DONE are ignored.
REQ-025 wr_en and rd_en both high: the write is performed and read_data is unchanged.
REQ-026 No re-trigger: after DONE the controller returns to IDLE and starts a new access only if a request is present in that later IDLE cycle.

Reset
REQ-027 On rst: state = IDLE, wait counter = 0, read_data = 0, SRAM_WE_N = 1, SRAM_DQ high-Z, SRAM_ADDR = 0.
REQ-028 rst asserted mid-access aborts the access; no further SRAM write strobe occurs; partially captured read halves are cleared.

Structure
REQ-029 State encodings, DATA_MEM_BASE and the WAIT_CYCLES default live in the shared constants file used by the pipeline stages.
REQ-030 Single module; no sub-module. The wait counter and tri-state driver are inline.

Verification
REQ-031 Write 0xDEADBEEF to address 1028, WAIT_CYCLES=2 -> ACC_LO: SRAM_ADDR=2, DQ=0xBEEF, WE_N=0; ACC_HI: SRAM_ADDR=3, DQ=0xDEAD, WE_N=0; ready low 5 cycles, then high 1 cycle.
REQ-032 Read from 1028 against an SRAM model holding that data -> read_data=0xDEADBEEF in the DONE cycle; WE_N stays 1 throughout.
REQ-033 Idle with rd_en=wr_en=0 for 10 cycles -> ready=1, WE_N=1, DQ=Z, read_data unchanged.
REQ-034 rst pulsed during ACC_HI of a write -> next cycle state IDLE, WE_N=1, read_data=0, and no further WE_N low pulse.
REQ-035 rd_en=wr_en=1 to address 1024 with write_data 0x12345678 -> SRAM words 0/1 = 0x5678/0x1234, and read_data is unchanged.
REQ-036 Back-to-back reads from 1024 and 1032, with the bench advancing the request when ready=1 -> second access enters ACC_LO two cycles after the first DONE; SRAM_ADDR 4/5 are used.
